// File: rtl/aurora_rx_checker.sv
// Aurora RX stream checker: seeds on an incrementing 32-bit pattern, then checks data,
// tkeep and frame length per beat, and keeps saturating frame/error counters.
//   state   | meaning
//   IDLE    | channel down, nothing tracked
//   SEEK    | channel up, waiting for the first beat of a frame to seed
//   CHECK   | seeded, every beat compared against the expected pattern
module aurora_rx_checker #(
  parameter int CNT_W           = 16,
  parameter int MAX_FRAME_BEATS = 256
) (
  input  logic             user_clk,
  input  logic             reset_n,
  input  logic [31:0]      rx_tdata,
  input  logic [3:0]       rx_tkeep,
  input  logic             rx_tvalid,
  input  logic             rx_tlast,
  input  logic             channel_up,
  input  logic             crc_valid,
  input  logic             crc_pass_fail_n,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] data_err_cnt,
  output logic [CNT_W-1:0] crc_err_cnt
);

  localparam int BW = $clog2(MAX_FRAME_BEATS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEEK  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [31:0]   expected;
  logic [BW-1:0] beat_cnt;
  logic          in_frame, frame_void, len_flag;
  logic          beat, seed, checking, keep_ok;
  logic          data_bad, keep_bad, len_bad, beat_err, crc_bad, frame_good;
  logic [3:0]    lane_miss;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    lane_miss = '0;
    beat      = rx_tvalid & channel_up;
    seed      = beat & (state == S_SEEK) & ~in_frame;
    checking  = beat & (state == S_CHECK);
    for (int i = 0; i < 4; i++)
      lane_miss[i] = rx_tkeep[i] & (rx_tdata[8*i +: 8] != expected[8*i +: 8]);
    if (rx_tlast)
      keep_ok = rx_tkeep inside {4'b1111, 4'b1110, 4'b1100, 4'b1000};
    else
      keep_ok = (rx_tkeep == 4'b1111);
    data_bad   = checking & (|lane_miss);
    keep_bad   = checking & ~keep_ok;
    // beat_cnt already holds MAX beats, so this beat is the first one over the limit
    len_bad    = checking & in_frame & ~len_flag & (beat_cnt == BW'(MAX_FRAME_BEATS));
    beat_err   = data_bad | keep_bad | len_bad;
    crc_bad    = crc_valid & ~crc_pass_fail_n;
    frame_good = checking & rx_tlast & ~beat_err & ~(in_frame & frame_void);

    state_nxt = state;
    if (!channel_up) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_SEEK;
        S_SEEK:  if (seed) state_nxt = S_CHECK;
        S_CHECK: state_nxt = S_CHECK;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      locked     <= 1'b0;
      expected   <= '0;
      beat_cnt   <= '0;
      in_frame   <= 1'b0;
      frame_void <= 1'b0;
      len_flag   <= 1'b0;
    end else begin
      state  <= state_nxt;
      locked <= (state_nxt == S_CHECK);
      if (!channel_up) begin
        beat_cnt   <= '0;
        in_frame   <= 1'b0;
        frame_void <= 1'b0;
        len_flag   <= 1'b0;
      end else if (seed | checking) begin
        expected <= rx_tdata + 32'd1;
        in_frame <= ~rx_tlast;
        if (rx_tlast)
          beat_cnt <= '0;
        else if (!in_frame)
          beat_cnt <= BW'(1);
        else if (beat_cnt != BW'(MAX_FRAME_BEATS))
          beat_cnt <= beat_cnt + BW'(1);
        len_flag   <= ~rx_tlast & ((in_frame & len_flag) | len_bad);
        // the seed frame was never fully checked, so it must not be counted as good
        frame_void <= ~rx_tlast & (seed | beat_err | (in_frame & frame_void));
      end
    end
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      err_pulse    <= 1'b0;
      frame_cnt    <= '0;
      data_err_cnt <= '0;
      crc_err_cnt  <= '0;
    end else begin
      err_pulse <= beat_err | crc_bad;
      if (clear) begin
        frame_cnt    <= '0;
        data_err_cnt <= '0;
        crc_err_cnt  <= '0;
      end else begin
        if (frame_good) frame_cnt    <= sat_inc(frame_cnt);
        if (beat_err)   data_err_cnt <= sat_inc(data_err_cnt);
        if (crc_bad)    crc_err_cnt  <= sat_inc(crc_err_cnt);
      end
    end
  end

endmodule

// File: tb/tb_aurora_rx_checker.sv
// Bench for aurora_rx_checker: directed vector table, hand sequences for saturation and
// async reset, then randomized traffic checked every cycle against a reference model.
module tb_aurora_rx_checker;
  localparam int CNT_W = 8;
  localparam int MAXB  = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             user_clk, reset_n;
  logic [31:0]      rx_tdata;
  logic [3:0]       rx_tkeep;
  logic             rx_tvalid, rx_tlast, channel_up, crc_valid, crc_pass_fail_n, clear;
  logic             locked, err_pulse;
  logic [CNT_W-1:0] frame_cnt, data_err_cnt, crc_err_cnt;

  aurora_rx_checker #(.CNT_W(CNT_W), .MAX_FRAME_BEATS(MAXB)) dut (
    .user_clk(user_clk), .reset_n(reset_n), .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep),
    .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .channel_up(channel_up),
    .crc_valid(crc_valid), .crc_pass_fail_n(crc_pass_fail_n), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .frame_cnt(frame_cnt),
    .data_err_cnt(data_err_cnt), .crc_err_cnt(crc_err_cnt));

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference model, frame-level view of the checking rules
  int          m_mode;            // 0 idle, 1 seeking, 2 checking
  logic [31:0] m_exp;
  bit          m_open, m_void, m_len_hit, m_locked, m_ep;
  int          m_len, m_frames, m_derr, m_cerr;

  function automatic int sat(input int x);
    return (x < CMAX) ? x + 1 : x;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_exp = '0; m_open = 0; m_void = 0; m_len_hit = 0; m_len = 0;
    m_frames = 0; m_derr = 0; m_cerr = 0; m_locked = 0; m_ep = 0;
  endtask

  task automatic model_step();
    bit e, crc_e, frame_inc;
    e = 0; frame_inc = 0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (!channel_up) begin
      m_mode = 0; m_open = 0; m_len = 0; m_void = 0; m_len_hit = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (rx_tvalid) begin
      if (m_mode == 1) begin
        m_exp = rx_tdata + 32'd1; m_mode = 2; m_open = !rx_tlast;
        m_len = 1; m_void = 1; m_len_hit = 0;
      end else begin
        if (!m_open) begin m_len = 0; m_void = 0; m_len_hit = 0; end
        m_len++;
        for (int b = 0; b < 4; b++)
          if (rx_tkeep[3-b] &&
              (((rx_tdata >> (24 - 8*b)) & 32'hFF) != ((m_exp >> (24 - 8*b)) & 32'hFF)))
            e = 1;
        if (rx_tlast) begin
          if (!(rx_tkeep == 4'hF || rx_tkeep == 4'hE || rx_tkeep == 4'hC || rx_tkeep == 4'h8))
            e = 1;
        end else if (rx_tkeep != 4'hF) e = 1;
        if (m_len > MAXB && !m_len_hit) begin e = 1; m_len_hit = 1; end
        if (e) m_void = 1;
        if (rx_tlast) begin frame_inc = !m_void; m_open = 0; end
        else m_open = 1;
        m_exp = rx_tdata + 32'd1;
      end
    end
    crc_e = crc_valid && !crc_pass_fail_n;
    if (clear) begin
      m_frames = 0; m_derr = 0; m_cerr = 0;
    end else begin
      if (frame_inc) m_frames = sat(m_frames);
      if (e)         m_derr   = sat(m_derr);
      if (crc_e)     m_cerr   = sat(m_cerr);
    end
    m_ep = e || crc_e;
    m_locked = (m_mode == 2);
  endtask

  task automatic cycle();
    @(posedge user_clk);
    model_step();
    #1;
    chk("model_locked", int'(locked), int'(m_locked));
    chk("model_err_pulse", int'(err_pulse), int'(m_ep));
    chk("model_frame_cnt", int'(frame_cnt), m_frames);
    chk("model_data_err_cnt", int'(data_err_cnt), m_derr);
    chk("model_crc_err_cnt", int'(crc_err_cnt), m_cerr);
  endtask

  task automatic drive(input bit cu, input bit v, input bit l, input logic [31:0] d,
                       input logic [3:0] k, input bit cv, input bit cp, input bit clr);
    channel_up = cu; rx_tvalid = v; rx_tlast = l; rx_tdata = d; rx_tkeep = k;
    crc_valid = cv; crc_pass_fail_n = cp; clear = clr;
  endtask

  typedef struct {
    bit cu, v, l, cv, cp, clr;
    logic [31:0] d;
    logic [3:0]  k;
    int lk, ep, f, de, ce;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit cu, input bit v, input bit l, input logic [31:0] d,
                              input logic [3:0] k, input bit cv, input bit cp, input bit clr,
                              input int lk, input int ep, input int f, input int de, input int ce);
    vec_t r;
    r.cu = cu; r.v = v; r.l = l; r.d = d; r.k = k; r.cv = cv; r.cp = cp; r.clr = clr;
    r.lk = lk; r.ep = ep; r.f = f; r.de = de; r.ce = ce;
    tbl.push_back(r);
  endfunction

  initial begin
    //  cu v l  data          keep cv cp clr | lk ep f de ce
    add(1, 0, 0, 32'h0,        4'hF, 0, 0, 0,   0, 0, 0, 0, 0);
    add(1, 1, 1, 32'h1,        4'hF, 0, 0, 0,   1, 0, 0, 0, 0);
    add(1, 1, 1, 32'h2,        4'hF, 0, 0, 0,   1, 0, 1, 0, 0);
    add(1, 1, 1, 32'h3,        4'hF, 0, 0, 0,   1, 0, 2, 0, 0);
    add(1, 1, 1, 32'h4,        4'hF, 0, 0, 0,   1, 0, 3, 0, 0);
    add(1, 1, 1, 32'h5,        4'hF, 0, 0, 0,   1, 0, 4, 0, 0);
    add(0, 0, 0, 32'h0,        4'hF, 0, 0, 0,   0, 0, 4, 0, 0);
    add(1, 0, 0, 32'h0,        4'hF, 0, 0, 0,   0, 0, 4, 0, 0);
    add(1, 1, 1, 32'h10,       4'hF, 0, 0, 0,   1, 0, 4, 0, 0);
    add(1, 1, 1, 32'h13,       4'hF, 0, 0, 0,   1, 1, 4, 1, 0);
    add(1, 1, 1, 32'h14,       4'hF, 0, 0, 0,   1, 0, 5, 1, 0);
    add(0, 0, 0, 32'h0,        4'hF, 0, 0, 0,   0, 0, 5, 1, 0);
    add(1, 0, 0, 32'h0,        4'hF, 0, 0, 0,   0, 0, 5, 1, 0);
    add(1, 1, 1, 32'hFFFFFFFD, 4'hF, 0, 0, 0,   1, 0, 5, 1, 0);
    add(1, 1, 1, 32'hFFFFFFFE, 4'hF, 0, 0, 0,   1, 0, 6, 1, 0);
    add(1, 1, 1, 32'hFFFFFFFF, 4'hF, 0, 0, 0,   1, 0, 7, 1, 0);
    add(1, 1, 1, 32'h00000000, 4'hF, 0, 0, 0,   1, 0, 8, 1, 0);
    add(1, 1, 0, 32'h1,        4'hF, 0, 0, 0,   1, 0, 8, 1, 0);
    add(1, 1, 0, 32'h2,        4'hE, 0, 0, 0,   1, 1, 8, 2, 0);
    add(1, 1, 1, 32'h3,        4'hF, 0, 0, 0,   1, 0, 8, 2, 0);
    add(1, 1, 1, 32'h5,        4'hF, 1, 0, 0,   1, 1, 8, 3, 1);
    add(1, 1, 1, 32'h7,        4'hF, 0, 0, 1,   1, 1, 0, 0, 0);
    add(1, 1, 1, 32'h8,        4'hF, 0, 0, 0,   1, 0, 1, 0, 0);
    for (int i = 0; i < MAXB; i++)
      add(1, 1, 0, 32'(9 + i), 4'hF, 0, 0, 0,   1, 0, 1, 0, 0);
    add(1, 1, 0, 32'h11,       4'hF, 0, 0, 0,   1, 1, 1, 1, 0);
    add(1, 1, 1, 32'h12,       4'hF, 0, 0, 0,   1, 0, 1, 1, 0);
    add(1, 1, 1, 32'h13,       4'h7, 0, 0, 0,   1, 1, 1, 2, 0);
    add(1, 1, 1, 32'h14,       4'hC, 0, 0, 0,   1, 0, 2, 2, 0);
    add(1, 1, 0, 32'h15,       4'hF, 0, 0, 0,   1, 0, 2, 2, 0);
    add(0, 1, 0, 32'h16,       4'hF, 0, 0, 0,   0, 0, 2, 2, 0);
    add(1, 0, 0, 32'h0,        4'hF, 0, 0, 0,   0, 0, 2, 2, 0);
    add(1, 1, 1, 32'h64,       4'hF, 0, 0, 0,   1, 0, 2, 2, 0);
    add(1, 1, 1, 32'h65,       4'hF, 1, 1, 0,   1, 0, 3, 2, 0);

    reset_n = 1'b0;
    drive(0, 0, 0, 32'h0, 4'hF, 0, 0, 0);
    model_reset();
    repeat (3) cycle();
    chk("reset_locked", int'(locked), 0);
    chk("reset_err_pulse", int'(err_pulse), 0);
    chk("reset_frame_cnt", int'(frame_cnt), 0);
    chk("reset_data_err_cnt", int'(data_err_cnt), 0);
    chk("reset_crc_err_cnt", int'(crc_err_cnt), 0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].cu, tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].k, tbl[i].cv, tbl[i].cp, tbl[i].clr);
      cycle();
      chk($sformatf("row%0d_locked", i), int'(locked), tbl[i].lk);
      chk($sformatf("row%0d_err_pulse", i), int'(err_pulse), tbl[i].ep);
      chk($sformatf("row%0d_frame_cnt", i), int'(frame_cnt), tbl[i].f);
      chk($sformatf("row%0d_data_err_cnt", i), int'(data_err_cnt), tbl[i].de);
      chk($sformatf("row%0d_crc_err_cnt", i), int'(crc_err_cnt), tbl[i].ce);
    end

    // 300 coincident data + CRC errors: both counters must stick at all-ones
    for (int i = 0; i < 300; i++) begin
      drive(1, 1, 1, 32'h0, 4'hF, 1, 0, 0);
      cycle();
    end
    chk("sat_data_err_cnt", int'(data_err_cnt), CMAX);
    chk("sat_crc_err_cnt", int'(crc_err_cnt), CMAX);
    chk("sat_frame_cnt", int'(frame_cnt), 3);
    chk("sat_err_pulse", int'(err_pulse), 1);
    drive(1, 1, 1, 32'h1, 4'hF, 0, 0, 0);
    cycle();
    chk("after_sat_err_pulse", int'(err_pulse), 0);
    chk("after_sat_frame_cnt", int'(frame_cnt), 4);
    chk("after_sat_data_err_cnt", int'(data_err_cnt), CMAX);

    // reset takes effect without waiting for a clock edge
    reset_n = 1'b0;
    #2;
    chk("async_rst_locked", int'(locked), 0);
    chk("async_rst_frame_cnt", int'(frame_cnt), 0);
    chk("async_rst_data_err_cnt", int'(data_err_cnt), 0);
    chk("async_rst_crc_err_cnt", int'(crc_err_cnt), 0);
    model_reset();
    drive(0, 0, 0, 32'h0, 4'hF, 0, 0, 0);
    cycle();
    reset_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      logic l;
      logic [3:0] k;
      logic [3:0] last_keeps [4];
      last_keeps[0] = 4'hF; last_keeps[1] = 4'hE; last_keeps[2] = 4'hC; last_keeps[3] = 4'h8;
      l = ($urandom_range(99) < 30);
      if ($urandom_range(99) < 85)
        k = l ? last_keeps[$urandom_range(3)] : 4'hF;
      else
        k = 4'($urandom_range(15));
      drive(($urandom_range(99) < 97), ($urandom_range(99) < 70), l,
            ($urandom_range(99) < 92) ? m_exp : $urandom, k,
            ($urandom_range(99) < 10), 1'($urandom_range(1)), ($urandom_range(999) < 5));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aurora_rx_checker.md
AURORA_RX_CHECKER -- requirements
Module: aurora_rx_checker

Interface
REQ-001 Parameter CNT_W, default 16: width of every saturating counter; legal range 8..32.
REQ-002 Parameter MAX_FRAME_BEATS, default 256: longest legal frame, in beats.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 user_clk  in  1  Aurora user clock; all logic on its rising edge.
REQ-005 reset_n  in  1  async active-low reset.
REQ-006 rx_tdata  in  32  Aurora RX stream data; byte 0 = [31:24].
REQ-007 rx_tkeep  in  4  byte enables; bit 3 = byte 0.
REQ-008 rx_tvalid  in  1  beat valid; no backpressure.
REQ-009 rx_tlast  in  1  last beat of frame.
REQ-010 channel_up  in  1  Aurora channel up.
REQ-011 crc_valid  in  1  CRC result strobe.
REQ-012 crc_pass_fail_n  in  1  1 = CRC pass; sampled only when crc_valid=1.
REQ-013 clear  in  1  synchronous counter clear pulse.
REQ-014 locked  out  1  checker seeded and checking.
REQ-015 err_pulse  out  1  one-cycle flag for any error detected this cycle.
REQ-016 frame_cnt  out  CNT_W  good frames received.
REQ-017 data_err_cnt  out  CNT_W  data, keep or length errors.
REQ-018 crc_err_cnt  out  CNT_W  CRC failures.

Function
REQ-019 FSM states SHALL be IDLE, SEEK and CHECK; a beat is a cycle with rx_tvalid=1.
REQ-020 IDLE -> SEEK when channel_up=1; any state -> IDLE in the cycle after channel_up=0, with locked=0 and the in-progress frame discarded.
REQ-021 SEEK: the first beat of a frame (no frame open) SHALL load expected = rx_tdata+1, set locked=1 next cycle and go to CHECK; that beat is not checked.
REQ-022 CHECK: for each beat, each enabled byte lane SHALL be compared with the same lane of expected; any mismatch is a data error; expected <= rx_tdata+1 after every beat (32-bit wrap, FFFFFFFF -> 00000000).
REQ-023 Non-last beat with rx_tkeep != 4'b1111 is a keep error; last beat SHALL have tkeep in {1111,1110,1100,1000}, otherwise keep error.
REQ-024 Beat counter resets at each tlast; a frame exceeding MAX_FRAME_BEATS beats is a length error, counted once, frame closed at next tlast.
REQ-025 At tlast, frame_cnt +1 only if the frame had no data/keep/length error.
REQ-026 Data, keep and length errors in one beat SHALL increment data_err_cnt by exactly 1.
REQ-027 crc_valid=1 with crc_pass_fail_n=0 increments crc_err_cnt in any state, independent of beats.
REQ-028 err_pulse=1 the cycle after any counter-incrementing error (data or CRC); simultaneous errors give one pulse.
REQ-029 All counters saturate at 2^CNT_W-1 and never wrap.
REQ-030 clear=1 zeroes all counters next cycle; clear wins over a simultaneous increment; FSM and expected unaffected.
REQ-031 Output latency: counters, locked and err_pulse registered, one cycle after the causing input.

Reset
REQ-032 reset_n=0 SHALL immediately force: state IDLE, locked=0, err_pulse=0, all counters 0, expected 0, beat counter 0.
REQ-033 Release of reset_n is synchronous to user_clk; first transition possible on the edge after deassertion.

Verification
REQ-034 channel_up=1, 1-beat frames 00000001..00000005 tkeep 1111 tlast=1 -> locked=1 after beat 1, frame_cnt=4, data_err_cnt=0.
REQ-035 Seeded at 00000010, next beat 00000013 -> err_pulse one cycle, data_err_cnt=1; next beat 00000014 checks clean.
REQ-036 Beats FFFFFFFE, FFFFFFFF, 00000000 -> no error (wrap); 3-beat frame with middle tkeep 1110 -> data_err_cnt=1, frame_cnt unchanged.
REQ-037 crc_valid=1 crc_pass_fail_n=0 coincident with data error -> both counters +1, single err_pulse; CNT_W=8, 300 errors -> data_err_cnt=FF.
REQ-038 channel_up drops mid-frame -> locked=0 next cycle, IDLE; on return, reseed without error; clear with simultaneous error -> counters 0.
